// File: rtl/macro_timing_ctrl_if.sv
// Handshake and strobe bundle between the window source, the timing controller and the macro.
// The slave modport is the controller side; the master modport is the driver/observer side.
interface macro_timing_ctrl_if;
    logic        mode_in;
    logic        verticle_sync;
    logic        win_valid;
    logic        partial_ready;
    logic        enable_to_macro;
    logic        latch_to_macro;
    logic        adc_to_macro;
    logic        partial_valid;
    logic        busy;
    logic        overrun;
    logic [15:0] win_cnt;

    modport slave (
        input  mode_in, verticle_sync, win_valid, partial_ready,
        output enable_to_macro, latch_to_macro, adc_to_macro, partial_valid, busy, overrun, win_cnt
    );

    modport master (
        output mode_in, verticle_sync, win_valid, partial_ready,
        input  enable_to_macro, latch_to_macro, adc_to_macro, partial_valid, busy, overrun, win_cnt
    );
endinterface

// File: rtl/macro_timing_ctrl.sv
// Sequences enable/latch/adc strobes of the compute macro for each 3x3 window; win_valid -> partial_valid in EN_CYC+LATCH_CYC+ADC_CYC+1 cycles.
// DONE holds until partial_ready; busy-time windows queue one deep when OVERRUN_QUEUE_EN is defined, otherwise drop and flag overrun.
module macro_timing_ctrl #(
    parameter int unsigned EN_CYC    = 4,
    parameter int unsigned LATCH_CYC = 4,
    parameter int unsigned ADC_CYC   = 3
) (
    input  logic               clk,
    input  logic               rstn,
    macro_timing_ctrl_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_LATCH, S_ADC, S_DONE} state_t;

    localparam logic [3:0] EN_LOAD    = 4'(EN_CYC - 1);
    localparam logic [3:0] LATCH_LOAD = 4'(LATCH_CYC - 1);
    localparam logic [3:0] ADC_LOAD   = 4'(ADC_CYC - 1);

    state_t      state_q, state_d;
    logic [3:0]  phase_q, phase_d;
    logic        pend_q, pend_d;
    logic        ovr_q, ovr_d;
    logic [15:0] cnt_q, cnt_d;
    logic        en_q, latch_q, adc_q, pv_q, busy_q;

    logic abort;
    logic done_hs;
    logic busy_win;

    assign abort    = bus.verticle_sync || !bus.mode_in;
    assign done_hs  = (state_q == S_DONE) && bus.partial_ready;
    assign busy_win = bus.win_valid && (state_q != S_IDLE) && !done_hs;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        pend_d  = pend_q;
        ovr_d   = ovr_q;
        cnt_d   = cnt_q;
        if (abort) begin
            state_d = S_IDLE;
            phase_d = '0;
            pend_d  = 1'b0;
            cnt_d   = '0;
            if (bus.verticle_sync) ovr_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.win_valid) begin
                        state_d = S_SETUP;
                        phase_d = EN_LOAD;
                        cnt_d   = cnt_q + 16'd1;
                    end
                end
                S_SETUP: begin
                    if (phase_q == 4'd0) begin
                        state_d = S_LATCH;
                        phase_d = LATCH_LOAD;
                    end else begin
                        phase_d = phase_q - 4'd1;
                    end
                end
                S_LATCH: begin
                    if (phase_q == 4'd0) begin
                        state_d = S_ADC;
                        phase_d = ADC_LOAD;
                    end else begin
                        phase_d = phase_q - 4'd1;
                    end
                end
                S_ADC: begin
                    if (phase_q == 4'd0) begin
                        state_d = S_DONE;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q - 4'd1;
                    end
                end
                S_DONE: begin
                    // A pending window restarts first; a same-cycle arrival then refills the slot.
                    if (done_hs) begin
                        if (pend_q || bus.win_valid) begin
                            state_d = S_SETUP;
                            phase_d = EN_LOAD;
                        end else begin
                            state_d = S_IDLE;
                        end
                        if (bus.win_valid) cnt_d = cnt_q + 16'd1;
                        pend_d = pend_q && bus.win_valid;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    phase_d = '0;
                end
            endcase

            if (busy_win) begin
`ifdef OVERRUN_QUEUE_EN
                if (pend_q) begin
                    ovr_d = 1'b1;
                end else begin
                    pend_d = 1'b1;
                    cnt_d  = cnt_q + 16'd1;
                end
`else
                ovr_d = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            pend_q  <= 1'b0;
            ovr_q   <= 1'b0;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            latch_q <= 1'b0;
            adc_q   <= 1'b0;
            pv_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            cnt_q   <= cnt_d;
            en_q    <= (state_d == S_SETUP) || (state_d == S_LATCH) || (state_d == S_ADC);
            latch_q <= (state_d == S_LATCH);
            adc_q   <= (state_d == S_ADC);
            pv_q    <= (state_d == S_DONE);
            busy_q  <= (state_d != S_IDLE);
        end
    end

    assign bus.enable_to_macro = en_q;
    assign bus.latch_to_macro  = latch_q;
    assign bus.adc_to_macro    = adc_q;
    assign bus.partial_valid   = pv_q;
    assign bus.busy            = busy_q;
    assign bus.overrun         = ovr_q;
    assign bus.win_cnt         = cnt_q;
endmodule

// File: tb/tb_macro_timing_ctrl.sv
// Directed scenarios plus random traffic against a window-age reference model of the timing controller.
module tb_macro_timing_ctrl;
    localparam int E = 4;
    localparam int L = 4;
    localparam int A = 3;
    localparam int T = E + L + A;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    macro_timing_ctrl_if bus();

    macro_timing_ctrl #(.EN_CYC(E), .LATCH_CYC(L), .ADC_CYC(A)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int npass = 0;
    int nfail = 0;
    int ntot  = 0;

    // Model: a window in flight is described only by its age in cycles since acceptance.
    bit m_act, m_pend, m_ovr;
    int m_age, m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_act = 0; m_pend = 0; m_ovr = 0; m_age = 0; m_cnt = 0;
    endtask

    task automatic check_out(input string ph);
        bit en, la, ad, pv;
        en = m_act && (m_age < T);
        la = m_act && (m_age >= E) && (m_age < E + L);
        ad = m_act && (m_age >= E + L) && (m_age < T);
        pv = m_act && (m_age >= T);
        chk({ph, ".en"},   bus.enable_to_macro, en);
        chk({ph, ".latch"}, bus.latch_to_macro, la);
        chk({ph, ".adc"},  bus.adc_to_macro, ad);
        chk({ph, ".pv"},   bus.partial_valid, pv);
        chk({ph, ".busy"}, bus.busy, m_act);
        chk({ph, ".ovr"},  bus.overrun, m_ovr);
        chk({ph, ".cnt"},  bus.win_cnt, 32'(m_cnt));
    endtask

    task automatic model_update(input bit wv, input bit rdy, input bit vs, input bit md);
        if (vs || !md) begin
            m_act = 0; m_pend = 0; m_cnt = 0;
            if (vs) m_ovr = 0;
        end else if (!m_act) begin
            if (wv) begin m_act = 1; m_age = 0; m_cnt = (m_cnt + 1) % 65536; end
        end else if (m_age >= T && rdy) begin
            if (m_pend) begin
                m_age = 0;
                m_pend = wv;
                if (wv) m_cnt = (m_cnt + 1) % 65536;
            end else if (wv) begin
                m_age = 0;
                m_cnt = (m_cnt + 1) % 65536;
            end else begin
                m_act = 0;
            end
        end else begin
            if (m_age < T) m_age++;
            if (wv) begin
`ifdef OVERRUN_QUEUE_EN
                if (m_pend) m_ovr = 1;
                else begin m_pend = 1; m_cnt = (m_cnt + 1) % 65536; end
`else
                m_ovr = 1;
`endif
            end
        end
    endtask

    // One cycle: check this cycle's outputs, apply inputs, advance across the rising edge.
    task automatic step(input string ph, input bit wv, input bit rdy, input bit vs, input bit md);
        check_out(ph);
        bus.win_valid     = wv;
        bus.partial_ready = rdy;
        bus.verticle_sync = vs;
        bus.mode_in       = md;
        @(posedge clk);
        model_update(wv, rdy, vs, md);
        @(negedge clk);
    endtask

    initial begin
        bus.mode_in = 1'b1; bus.verticle_sync = 1'b0; bus.win_valid = 1'b0; bus.partial_ready = 1'b1;
        rstn = 1'b0;
        model_reset();
        #12;
        check_out("reset");
        @(negedge clk);
        rstn = 1'b1;

        // Single window, consumer always ready
        step("s1", 1, 1, 0, 1);
        for (int k = 1; k <= 13; k++) step("s1", 0, 1, 0, 1);
        chk("s1.cnt_final", bus.win_cnt, 1);

        // Consumer stalls five cycles in DONE
        step("s2", 1, 1, 0, 1);
        for (int k = 1; k <= 17; k++) step("s2", 0, (k < 12 || k > 16), 0, 1);
        chk("s2.idle18", bus.busy, 0);

        // Second window mid-flight
        step("clr3", 0, 1, 1, 1);
        for (int k = 0; k <= 12; k++) step("s3", (k == 0 || k == 6), 1, 0, 1);
`ifdef OVERRUN_QUEUE_EN
        chk("s3.en13", bus.enable_to_macro, 1);
        chk("s3.ovr", bus.overrun, 0);
        chk("s3.cnt", bus.win_cnt, 2);
`else
        chk("s3.en13", bus.enable_to_macro, 0);
        chk("s3.ovr", bus.overrun, 1);
        chk("s3.cnt", bus.win_cnt, 1);
`endif
        for (int k = 0; k < 14; k++) step("s3t", 0, 1, 0, 1);

        // Frame start aborts a window and clears overrun
        step("clr4", 0, 1, 1, 1);
        for (int k = 0; k <= 6; k++) step("s4", (k == 0 || k == 2 || k == 3), 1, 0, 1);
        chk("s4.ovr_set", bus.overrun, 1);
        step("s4", 0, 1, 1, 1);
        chk("s4.en8", bus.enable_to_macro, 0);
        chk("s4.latch8", bus.latch_to_macro, 0);
        chk("s4.cnt8", bus.win_cnt, 0);
        chk("s4.ovr8", bus.overrun, 0);
        for (int k = 0; k < 8; k++) step("s4t", 0, 1, 0, 1);

        // Parameter-load mode ignores windows
        for (int k = 0; k < 10; k++) step("s5", k[0], 1, 0, 0);
        chk("s5.busy", bus.busy, 0);
        chk("s5.cnt", bus.win_cnt, 0);

        // Overrun survives parameter-load mode
        for (int k = 0; k <= 2; k++) step("s6", 1, 1, 0, 1);
        for (int k = 0; k < 4; k++) step("s6", 0, 1, 0, 0);
        chk("s6.ovr_hold", bus.overrun, 1);

        // Asynchronous reset in mid-ADC, then immediate acceptance
        step("clr7", 0, 1, 1, 1);
        for (int k = 0; k <= 8; k++) step("s7", (k == 0), 1, 0, 1);
        check_out("s7.c9");
        #1 rstn = 1'b0;
        #1;
        chk("s7.en", bus.enable_to_macro, 0);
        chk("s7.adc", bus.adc_to_macro, 0);
        chk("s7.busy", bus.busy, 0);
        chk("s7.cnt", bus.win_cnt, 0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        step("s8", 1, 1, 0, 1);
        chk("s8.busy", bus.busy, 1);
        for (int k = 0; k < 14; k++) step("s8", 0, 1, 0, 1);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            step("rnd", ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 49) == 0), ($urandom_range(0, 39) != 0));
        end
        check_out("end");

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
